// File: rtl/mips_ctrl_fsm_if.sv
// Control/datapath handshake bundle for the multicycle MIPS main controller.
// The memready signal exists only when CTRL_STALL_EN is defined.
interface mips_ctrl_fsm_if #(
  parameter int STATE_WIDTH = 5,
  parameter int OP_WIDTH    = 6
);
  logic [OP_WIDTH-1:0]    op;
  logic [STATE_WIDTH-1:0] nextstate;
  logic                   zero;
`ifdef CTRL_STALL_EN
  logic                   memready;
`endif
  logic                   memread;
  logic                   memwrite;
  logic                   iord;
  logic                   alusrca;
  logic                   memtoreg;
  logic                   regdst;
  logic                   regwrite;
  logic                   pcen;
  logic [3:0]             irwrite;
  logic [1:0]             alusrcb;
  logic [1:0]             aluop;
  logic [1:0]             pcsource;
  logic [1:0]             bytesel;
  logic                   illegal;

  modport master (
`ifdef CTRL_STALL_EN
    output memready,
`endif
    output op, nextstate, zero,
    input  memread, memwrite, iord, alusrca, memtoreg, regdst, regwrite, pcen,
    input  irwrite, alusrcb, aluop, pcsource, bytesel, illegal
  );

  modport slave (
`ifdef CTRL_STALL_EN
    input  memready,
`endif
    input  op, nextstate, zero,
    output memread, memwrite, iord, alusrca, memtoreg, regdst, regwrite, pcen,
    output irwrite, alusrcb, aluop, pcsource, bytesel, illegal
  );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multicycle main control FSM for the 8-bit-datapath MIPS core.
// Define CTRL_STALL_EN to hold memory/fetch states until memready.
module mips_ctrl_fsm #(
  parameter int STATE_WIDTH = 5,
  parameter int OP_WIDTH    = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  mips_ctrl_fsm_if.slave bus
);
  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH1  = 5'd0,  FETCH2  = 5'd1,  FETCH3 = 5'd2,  FETCH4 = 5'd3,
    DECODE  = 5'd4,  MEMADR  = 5'd5,  LBRD   = 5'd6,  LBWR   = 5'd7,
    SBWR    = 5'd8,  RTYPEEX = 5'd9,  RTYPEWR = 5'd10, BEQEX = 5'd11,
    JEX     = 5'd12, ADDIEX  = 5'd13, ADDIWR = 5'd14, LWRD   = 5'd15,
    LWWR    = 5'd16, SWWR    = 5'd17
  } state_e;

  localparam logic [OP_WIDTH-1:0] OP_LB = 6'b100000;
  localparam logic [OP_WIDTH-1:0] OP_SB = 6'b101000;
  localparam logic [OP_WIDTH-1:0] OP_LW = 6'b100011;
  localparam logic [OP_WIDTH-1:0] OP_SW = 6'b101011;

  state_e     state_r, state_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       adv_s, illegal_s;
  logic       memread_s, memwrite_s, iord_s, alusrca_s, memtoreg_s;
  logic       regdst_s, regwrite_s, pcen_s;
  logic [3:0] irwrite_s;
  logic [1:0] alusrcb_s, aluop_s, pcsource_s;
  logic       strobe_s;

`ifdef CTRL_STALL_EN
  // Memory-facing states wait for memready; all others always advance.
  always_comb begin
    adv_s = 1'b1;
    case (state_r)
      FETCH1, FETCH2, FETCH3, FETCH4, LBRD, SBWR, LWRD, SWWR: adv_s = bus.memready;
      default: adv_s = 1'b1;
    endcase
  end
`else
  assign adv_s = 1'b1;
`endif

  // State and byte-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= FETCH1;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state, byte counter and illegal-dispatch detection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = 2'd0;
    illegal_s   = 1'b0;
    case (state_r)
      FETCH1: state_nxt_s = FETCH2;
      FETCH2: state_nxt_s = FETCH3;
      FETCH3: state_nxt_s = FETCH4;
      FETCH4: state_nxt_s = DECODE;
      DECODE: begin
        case (bus.nextstate)
          MEMADR, RTYPEEX, BEQEX, ADDIEX, JEX: state_nxt_s = state_e'(bus.nextstate);
          default: begin
            state_nxt_s = FETCH1;
            illegal_s   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        case (bus.op)
          OP_LB:   state_nxt_s = LBRD;
          OP_SB:   state_nxt_s = SBWR;
          OP_LW:   state_nxt_s = LWRD;
          OP_SW:   state_nxt_s = SWWR;
          default: state_nxt_s = FETCH1;
        endcase
      end
      LBRD:    state_nxt_s = LBWR;
      RTYPEEX: state_nxt_s = RTYPEWR;
      ADDIEX:  state_nxt_s = ADDIWR;
      LWRD, SWWR: begin
        // Counter wraps to 0 on the fourth byte, which is also the exit cycle.
        cnt_nxt_s = cnt_r + 2'd1;
        if (cnt_r == 2'd3) begin
          state_nxt_s = (state_r == LWRD) ? LWWR : FETCH1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = FETCH1;
    endcase
    if (!adv_s) begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end else begin
      cnt_nxt_s   = cnt_nxt_s;
    end
  end

  // Moore output decode (BEQ pcen follows zero).
  always_comb begin
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    iord_s     = 1'b0;
    alusrca_s  = 1'b0;
    memtoreg_s = 1'b0;
    regdst_s   = 1'b0;
    regwrite_s = 1'b0;
    pcen_s     = 1'b0;
    irwrite_s  = 4'b0000;
    alusrcb_s  = 2'b00;
    aluop_s    = 2'b00;
    pcsource_s = 2'b00;
    case (state_r)
      FETCH1:  begin memread_s = 1'b1; irwrite_s = 4'b0001; alusrcb_s = 2'b01; pcen_s = 1'b1; end
      FETCH2:  begin memread_s = 1'b1; irwrite_s = 4'b0010; alusrcb_s = 2'b01; pcen_s = 1'b1; end
      FETCH3:  begin memread_s = 1'b1; irwrite_s = 4'b0100; alusrcb_s = 2'b01; pcen_s = 1'b1; end
      FETCH4:  begin memread_s = 1'b1; irwrite_s = 4'b1000; alusrcb_s = 2'b01; pcen_s = 1'b1; end
      DECODE:  alusrcb_s = 2'b11;
      MEMADR, ADDIEX: begin alusrca_s = 1'b1; alusrcb_s = 2'b10; end
      LBRD, LWRD: begin memread_s = 1'b1; iord_s = 1'b1; end
      SBWR, SWWR: begin memwrite_s = 1'b1; iord_s = 1'b1; end
      LBWR, LWWR: begin regwrite_s = 1'b1; memtoreg_s = 1'b1; end
      RTYPEEX: begin alusrca_s = 1'b1; aluop_s = 2'b10; end
      RTYPEWR: begin regdst_s = 1'b1; regwrite_s = 1'b1; end
      BEQEX:   begin alusrca_s = 1'b1; aluop_s = 2'b01; pcsource_s = 2'b01; pcen_s = bus.zero; end
      JEX:     begin pcsource_s = 2'b10; pcen_s = 1'b1; end
      ADDIWR:  regwrite_s = 1'b1;
      default: regwrite_s = 1'b0;
    endcase
  end

  // Reset gates everything; a stall additionally masks the state-changing strobes.
  assign strobe_s     = reset_n & adv_s;
  assign bus.memread  = reset_n & memread_s;
  assign bus.memwrite = strobe_s & memwrite_s;
  assign bus.iord     = reset_n & iord_s;
  assign bus.alusrca  = reset_n & alusrca_s;
  assign bus.memtoreg = reset_n & memtoreg_s;
  assign bus.regdst   = reset_n & regdst_s;
  assign bus.regwrite = reset_n & regwrite_s;
  assign bus.pcen     = strobe_s & pcen_s;
  assign bus.irwrite  = {4{strobe_s}} & irwrite_s;
  assign bus.alusrcb  = {2{reset_n}} & alusrcb_s;
  assign bus.aluop    = {2{reset_n}} & aluop_s;
  assign bus.pcsource = {2{reset_n}} & pcsource_s;
  assign bus.bytesel  = {2{reset_n}} & cnt_r;
  assign bus.illegal  = reset_n & illegal_s;
endmodule
